// File: rtl/fp64_div_pkg.sv
// fp64_div_pkg
// Shared constants and types for the sequential binary64 divider.
//   - binary64 exponent constants and special encodings
//   - FSM state encoding (plain constants, legacy-compatible)
//   - bit positions inside the 4-bit result flag vector
//   - operand class enum produced by fp64_unpack
package fp64_div_pkg;

    localparam int          EXP_BIAS = 1023;
    localparam int          EXP_MAX  = 2047;
    localparam logic [63:0] QNAN     = 64'h7FF8000000000000;
    localparam logic [63:0] POS_INF  = 64'h7FF0000000000000;

    // Divider FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_PACK = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // out_flags = {invalid, div_by_zero, overflow, underflow}
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_DIV_ZERO  = 2;
    localparam int FLAG_OVERFLOW  = 1;
    localparam int FLAG_UNDERFLOW = 0;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        INF  = 2'd1,
        NAN  = 2'd2,
        NORM = 2'd3
    } op_class_t;

endpackage

// File: rtl/fp64_unpack.sv
// fp64_unpack
// Combinational split and classification of one binary64 operand.
// Ports:
//   value     in   64  binary64 operand
//   sign      out   1  sign bit
//   exp_field out  11  biased exponent field
//   man       out  53  significand with the hidden one prepended
//   cls       out      operand class (ZERO, INF, NAN, NORM)
// Subnormals are classified as ZERO so the datapath only ever sees
// normalised significands.
module fp64_unpack
    import fp64_div_pkg::*;
(
    input  logic [63:0] value,
    output logic        sign,
    output logic [10:0] exp_field,
    output logic [52:0] man,
    output op_class_t   cls
);

    assign sign      = value[63];
    assign exp_field = value[62:52];
    assign man       = {1'b1, value[51:0]};

    always_comb begin
        cls = NORM;
        if (value[62:52] == 11'd0) begin
            cls = ZERO;
        end else if (value[62:52] == 11'h7FF) begin
            cls = (value[51:0] == 52'd0) ? INF : NAN;
        end
    end

endmodule

// File: rtl/fp64_div_seq.sv
// fp64_div_seq
// Sequential IEEE-754 binary64 divider, radix-2 restoring, one quotient
// bit per cycle, valid/ready on both operand and result sides.
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  operand pair offered
//   in_ready   out  1  high only in IDLE
//   in_a       in  64  dividend
//   in_b       in  64  divisor
//   out_valid  out  1  result held (DONE)
//   out_ready  in   1  consumer accepts the result
//   out_data   out 64  quotient
//   out_flags  out  4  {invalid, div_by_zero, overflow, underflow}
// Build option: define FP64_DIV_RNE_EN for round-to-nearest-even; without
// it the quotient is truncated (round toward zero).
module fp64_div_seq
    import fp64_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_a,
    input  logic [63:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [3:0]  out_flags
);

    logic [1:0]         state;
    logic [5:0]         cnt;
    logic [53:0]        rem;
    logic [53:0]        quo;
    logic [52:0]        mb_r;
    logic signed [12:0] exp_r;
    logic               sign_r;

    logic               sa, sb;
    logic [10:0]        ea, eb;
    logic [52:0]        ma, mb;
    op_class_t          cls_a, cls_b;

    fp64_unpack u_unpack_a (
        .value     (in_a),
        .sign      (sa),
        .exp_field (ea),
        .man       (ma),
        .cls       (cls_a)
    );

    fp64_unpack u_unpack_b (
        .value     (in_b),
        .sign      (sb),
        .exp_field (eb),
        .man       (mb),
        .cls       (cls_b)
    );

    logic sign_q;
    assign sign_q   = sa ^ sb;
    assign in_ready = (state == ST_IDLE);

    // Special-case decode; priority order matters: NaN/0-0/inf-inf first,
    // then inf dividend (covers inf/0 without a div_by_zero flag).
    logic        is_special;
    logic [63:0] spec_data;
    logic [3:0]  spec_flags;

    always_comb begin
        is_special = 1'b1;
        spec_data  = 64'd0;
        spec_flags = 4'd0;
        if (cls_a == NAN || cls_b == NAN ||
            (cls_a == ZERO && cls_b == ZERO) ||
            (cls_a == INF && cls_b == INF)) begin
            spec_data                = QNAN;
            spec_flags[FLAG_INVALID] = 1'b1;
        end else if (cls_a == INF) begin
            spec_data = {sign_q, POS_INF[62:0]};
        end else if (cls_b == ZERO) begin
            spec_data                 = {sign_q, POS_INF[62:0]};
            spec_flags[FLAG_DIV_ZERO] = 1'b1;
        end else if (cls_a == ZERO || cls_b == INF) begin
            spec_data = {sign_q, 63'd0};
        end else begin
            is_special = 1'b0;
        end
    end

    // Pre-normalise so the quotient lands in [1,2): a dividend significand
    // smaller than the divisor is doubled and the exponent compensated.
    logic               adj;
    logic [53:0]        rem_init;
    logic signed [12:0] exp_init;

    always_comb begin
        adj      = (ma < mb);
        rem_init = adj ? {ma, 1'b0} : {1'b0, ma};
        exp_init = {2'b00, ea} - {2'b00, eb} + 13'(EXP_BIAS) - {12'd0, adj};
    end

    // One restoring step: compare, conditionally subtract, then shift.
    // The remainder stays below 2*mb, so 54 bits always suffice.
    logic        ge;
    logic [53:0] rem_sub;
    logic [53:0] rem_next;
    logic [53:0] quo_next;

    always_comb begin
        ge       = (rem >= {1'b0, mb_r});
        rem_sub  = ge ? (rem - {1'b0, mb_r}) : rem;
        rem_next = {rem_sub[52:0], 1'b0};
        quo_next = {quo[52:0], ge};
    end

    // Rounding and exponent range check. quo[53:1] is the 53-bit
    // significand, quo[0] the guard bit, and a nonzero remainder is sticky.
    logic               round_up;
    logic [53:0]        mant_sum;
    logic               carry;
    logic [51:0]        frac;
    logic signed [12:0] exp_rnd;
    logic [63:0]        pack_data;
    logic [3:0]         pack_flags;

`ifdef FP64_DIV_RNE_EN
    logic guard;
    logic sticky;
    assign guard    = quo[0];
    assign sticky   = (rem != 54'd0);
    assign round_up = guard && (sticky || quo[1]);
`else
    assign round_up = 1'b0;
`endif

    always_comb begin
        mant_sum   = {1'b0, quo[53:1]} + {53'd0, round_up};
        carry      = mant_sum[53];
        frac       = carry ? 52'd0 : mant_sum[51:0];
        exp_rnd    = exp_r + {12'd0, carry};
        pack_data  = {sign_r, exp_rnd[10:0], frac};
        pack_flags = 4'd0;
        if (exp_rnd >= $signed(13'(EXP_MAX))) begin
            pack_data                 = {sign_r, POS_INF[62:0]};
            pack_flags[FLAG_OVERFLOW] = 1'b1;
        end else if (exp_rnd <= 13'sd0) begin
            pack_data                  = {sign_r, 63'd0};
            pack_flags[FLAG_UNDERFLOW] = 1'b1;
        end
    end

    // Control FSM plus datapath registers. Specials skip straight to DONE;
    // normal operands iterate 54 times in DIV (counter 53..0), then PACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 6'd0;
            rem       <= 54'd0;
            quo       <= 54'd0;
            mb_r      <= 53'd0;
            exp_r     <= 13'sd0;
            sign_r    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 64'd0;
            out_flags <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sign_r <= sign_q;
                        if (is_special) begin
                            out_data  <= spec_data;
                            out_flags <= spec_flags;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            rem   <= rem_init;
                            mb_r  <= mb;
                            exp_r <= exp_init;
                            quo   <= 54'd0;
                            cnt   <= 6'd53;
                            state <= ST_DIV;
                        end
                    end
                end
                ST_DIV: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    if (cnt == 6'd0) begin
                        state <= ST_PACK;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                ST_PACK: begin
                    out_data  <= pack_data;
                    out_flags <= pack_flags;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp64_div_seq.sv
// tb_fp64_div_seq
// Directed self-checking bench for fp64_div_seq. Expected quotients,
// flags and latencies are hand-computed constants.
module tb_fp64_div_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_flags;

    int total = 0;
    int bad   = 0;

    fp64_div_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic doCheck(input string tag, input logic [63:0] observed,
                           input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Offer one operand pair; returns #1 after the accept edge.
    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b);
        int waitCnt;
        waitCnt = 0;
        @(negedge clk);
        while (!in_ready && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        doCheck("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges (accept edge is edge 1) until out_valid, then check result.
    task automatic checkOutput(input string tag, input logic [63:0] expData,
                               input logic [3:0] expFlags, input int expLat);
        int lat;
        lat = 1;
        while (!out_valid && lat < 200) begin
            doCheck({tag, "_busy_in_ready"}, {63'd0, in_ready}, 64'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        doCheck({tag, "_latency"}, 64'(lat), 64'(expLat));
        doCheck({tag, "_data"}, out_data, expData);
        doCheck({tag, "_flags"}, {60'd0, out_flags}, {60'd0, expFlags});
    endtask

    task automatic retireResult(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        doCheck({tag, "_retire_valid"}, {63'd0, out_valid}, 64'd0);
        doCheck({tag, "_retire_in_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    logic [63:0] heldData;
    logic [63:0] expOneTenth;

    initial begin
`ifdef FP64_DIV_RNE_EN
        expOneTenth = 64'h3FB999999999999A;
`else
        expOneTenth = 64'h3FB9999999999999;
`endif
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = 64'd0;
        in_b      = 64'd0;

        // Reset state
        #2;
        rst_n = 1'b0;
        #1;
        doCheck("reset_out_valid", {63'd0, out_valid}, 64'd0);
        doCheck("reset_out_data", out_data, 64'd0);
        doCheck("reset_out_flags", {60'd0, out_flags}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        doCheck("reset_in_ready", {63'd0, in_ready}, 64'd1);

        // 6.0 / 2.0
        applyStimulus(64'h4018000000000000, 64'h4000000000000000);
        checkOutput("six_by_two", 64'h4008000000000000, 4'b0000, 56);
        retireResult("six_by_two");

        // 1.0 / 10.0, result depends on rounding build
        applyStimulus(64'h3FF0000000000000, 64'h4024000000000000);
        checkOutput("one_by_ten", expOneTenth, 4'b0000, 56);
        retireResult("one_by_ten");

        // Specials
        applyStimulus(64'hBFF0000000000000, 64'h0000000000000000);
        checkOutput("neg_one_by_zero", 64'hFFF0000000000000, 4'b0100, 1);
        retireResult("neg_one_by_zero");

        applyStimulus(64'h0000000000000000, 64'h0000000000000000);
        checkOutput("zero_by_zero", 64'h7FF8000000000000, 4'b1000, 1);
        retireResult("zero_by_zero");

        applyStimulus(64'h7FF0000000000000, 64'h4000000000000000);
        checkOutput("inf_by_two", 64'h7FF0000000000000, 4'b0000, 1);
        retireResult("inf_by_two");

        applyStimulus(64'hC008000000000000, 64'h7FF0000000000000);
        checkOutput("neg_three_by_inf", 64'h8000000000000000, 4'b0000, 1);
        retireResult("neg_three_by_inf");

        applyStimulus(64'h7FF0000000000001, 64'h3FF0000000000000);
        checkOutput("nan_by_one", 64'h7FF8000000000000, 4'b1000, 1);
        retireResult("nan_by_one");

        applyStimulus(64'h0000000000000001, 64'h3FF0000000000000);
        checkOutput("subnormal_by_one", 64'h0000000000000000, 4'b0000, 1);
        retireResult("subnormal_by_one");

        // Range limits
        applyStimulus(64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000);
        checkOutput("overflow", 64'h7FF0000000000000, 4'b0010, 56);
        retireResult("overflow");

        applyStimulus(64'h0010000000000000, 64'h4000000000000000);
        checkOutput("underflow", 64'h0000000000000000, 4'b0001, 56);
        retireResult("underflow");

        // Backpressure: result held for 20 cycles with out_ready low
        applyStimulus(64'h4018000000000000, 64'h4000000000000000);
        checkOutput("backpressure", 64'h4008000000000000, 4'b0000, 56);
        heldData = 64'h4008000000000000;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            doCheck("stall_out_data", out_data, heldData);
            doCheck("stall_out_valid", {63'd0, out_valid}, 64'd1);
            doCheck("stall_in_ready", {63'd0, in_ready}, 64'd0);
        end
        retireResult("backpressure");

        // Abort with reset in DIV cycle 30
        applyStimulus(64'h4018000000000000, 64'h4000000000000000);
        repeat (29) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        doCheck("abort_out_valid_in_reset", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        doCheck("abort_out_valid", {63'd0, out_valid}, 64'd0);
        doCheck("abort_in_ready", {63'd0, in_ready}, 64'd1);
        applyStimulus(64'h4018000000000000, 64'h4000000000000000);
        checkOutput("after_abort", 64'h4008000000000000, 4'b0000, 56);
        retireResult("after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
